// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter
// Round-robin front end that shares one sequential 16x16 signed Booth
// multiplier core between NREQ requesters. One transaction is in flight at a
// time: accept operands, pulse the core, wait for done, return the product
// tagged with the requester index on a valid/ready response channel.
//
// Optional watchdog on the WAIT state: compile with BOOTH_MUL_TIMEOUT_EN.
// Without it, WAIT waits indefinitely and rsp_err is constant 0.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | arbitrate; grant handshakes combinationally, operands are latched
// ISSUE | one-cycle core_start pulse
// WAIT  | wait for core_done (or watchdog expiry when compiled in)
// RESP  | hold response until rsp_ready, then rotate priority
module booth_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*16-1:0] req_x,
  input  logic [NREQ*16-1:0] req_y,
  output logic               core_start,
  output logic [15:0]        core_x,
  output logic [15:0]        core_y,
  input  logic               core_done,
  input  logic [31:0]        core_prod,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_prod,
  output logic [ID_W-1:0]    rsp_id,
  output logic               rsp_err,
  output logic               busy
);

  if (NREQ < 2 || NREQ > 8 || (2**ID_W) < NREQ || TIMEOUT < 1) begin : g_param_check
    $error("booth_mul_arbiter: illegal NREQ/ID_W/TIMEOUT combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic            grant_vld;
  logic [ID_W-1:0] grant_id;
  logic [NREQ-1:0] grant_oh;
  logic [15:0]     sel_x;
  logic [15:0]     sel_y;
  logic            wd_expired;

  // Round-robin pick: lowest valid index at or above rr_ptr, else wrap to
  // the lowest valid index overall. Also muxes the winner's operands.
  always_comb begin
    grant_vld = |req_valid;
    grant_id  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[k]) grant_id = ID_W'(k);
    end
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[k] && (ID_W'(k) >= rr_ptr)) grant_id = ID_W'(k);
    end
    grant_oh = '0;
    sel_x    = '0;
    sel_y    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_vld && (grant_id == ID_W'(k))) begin
        grant_oh[k] = 1'b1;
        sel_x       = req_x[16*k +: 16];
        sel_y       = req_y[16*k +: 16];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; core_done only matters in WAIT, so stale strobes vanish.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (grant_vld) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (core_done || wd_expired) state_nxt = ST_RESP;
      ST_RESP:  if (rsp_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Moore outputs plus the combinational grant in IDLE.
  always_comb begin
    req_ready  = '0;
    core_start = 1'b0;
    rsp_valid  = 1'b0;
    busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE:  req_ready  = grant_oh;
      ST_ISSUE: core_start = 1'b1;
      ST_RESP:  rsp_valid  = 1'b1;
      default:  ;
    endcase
  end

  // Operand/ID capture on grant, product capture in WAIT, priority rotation
  // on the response handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_x   <= '0;
      core_y   <= '0;
      rsp_id   <= '0;
      rsp_prod <= '0;
      rr_ptr   <= '0;
    end else begin
      if (state == ST_IDLE && grant_vld) begin
        core_x <= sel_x;
        core_y <= sel_y;
        rsp_id <= grant_id;
      end
      if (state == ST_WAIT) begin
        if (core_done)       rsp_prod <= core_prod;
        else if (wd_expired) rsp_prod <= '0;
      end
      if (state == ST_RESP && rsp_ready) begin
        rr_ptr <= (rsp_id == ID_W'(NREQ - 1)) ? '0 : rsp_id + ID_W'(1);
      end
    end
  end

`ifdef BOOTH_MUL_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [WD_W-1:0] wd_cnt;

  // Expiry when the down-counter sits at zero in WAIT: TIMEOUT WAIT cycles.
  assign wd_expired = (state == ST_WAIT) && (wd_cnt == '0);

  // Watchdog down-counter, loaded in ISSUE so it is fresh on entry to WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
    end else if (state == ST_ISSUE) begin
      wd_cnt <= WD_W'(TIMEOUT - 1);
    end else if (state == ST_WAIT && wd_cnt != '0) begin
      wd_cnt <= wd_cnt - WD_W'(1);
    end
  end

  // Error flag: a real done always wins over expiry in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_err <= 1'b0;
    end else if (state == ST_WAIT) begin
      if (core_done)       rsp_err <= 1'b0;
      else if (wd_expired) rsp_err <= 1'b1;
    end
  end
`else
  assign wd_expired = 1'b0;
  assign rsp_err    = 1'b0;
`endif

endmodule
